// File: rtl/switch_conditioner.sv
// switch_conditioner
//   Input conditioning for a bank of mechanical switch levers. Each bit
//   passes through a 2-flop synchronizer and then a debounce counter.
//   The stable level changes only after the synchronized input has differed
//   from it for DEBOUNCE_CYCLES consecutive cycles. Single-cycle ROSE/FELL
//   pulses mark each change of the stable level.
//
//   Optional build macro: SWITCH_COND_TOGGLE_EN
//     defined   : T[n] flips each time Q[n] rises, so each press/release
//                 flips it once.
//     undefined : T is tied to 0 and no toggle flops exist.
//
// Ports
//   CLK   in   1        rising-edge clock
//   RST   in   1        synchronous, active-high reset
//   I     in   NSWITCH  raw switch levels, asynchronous to CLK
//   Q     out  NSWITCH  debounced stable level
//   ROSE  out  NSWITCH  one-cycle pulse, aligned with Q going 0->1
//   FELL  out  NSWITCH  one-cycle pulse, aligned with Q going 1->0
//   T     out  NSWITCH  toggle level (see macro above)
module switch_conditioner #(
   parameter int NSWITCH         = 2,
   parameter int DEBOUNCE_CYCLES = 4,
   localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NSWITCH-1:0] I,
   output logic [NSWITCH-1:0] Q,
   output logic [NSWITCH-1:0] ROSE,
   output logic [NSWITCH-1:0] FELL,
   output logic [NSWITCH-1:0] T
);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("switch_conditioner: DEBOUNCE_CYCLES must be >= 1");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   for (genvar n = 0; n < NSWITCH; n++) begin : g_bit
      logic             s1, s2;
      logic             q, rose, fell;
      logic [CNT_W-1:0] cnt;
      logic             commit;

      // Input has disagreed with the stable level long enough to accept it.
      assign commit = (s2 != q) && (cnt == CNT_MAX);

      always_ff @(posedge CLK) begin
         if (RST) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            q    <= 1'b0;
            rose <= 1'b0;
            fell <= 1'b0;
         end else begin
            s1   <= I[n];
            s2   <= s1;
            rose <= 1'b0;
            fell <= 1'b0;
            if (s2 == q) begin
               // Any return to the stable level discards partial progress.
               cnt <= '0;
            end else if (commit) begin
               q    <= s2;
               cnt  <= '0;
               rose <= s2;
               fell <= ~s2;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end
      end

      assign Q[n]    = q;
      assign ROSE[n] = rose;
      assign FELL[n] = fell;

`ifdef SWITCH_COND_TOGGLE_EN
      logic t;

      // Flip on the same edge that raises Q, so T changes with ROSE.
      always_ff @(posedge CLK) begin
         if (RST)
            t <= 1'b0;
         else if (commit && s2)
            t <= ~t;
      end

      assign T[n] = t;
`else
      assign T[n] = 1'b0;
`endif
   end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Upstream input stage placed between the MCPNR_SWITCHES bank and the combinational logic under test.
- Per-bit flow: raw lever outputs -> 2-flop synchronizer -> debounce over a fixed cycle count.
- Outputs: a clean level per switch, plus single-cycle ROSE and FELL pulses per switch.
- Lets downstream gates and sequential tests see stable, edge-qualified inputs rather than raw, asynchronously toggled levers.

Parameters:
- NSWITCH, 2, number of switch bits conditioned; must match the NSWITCH of the driving switch bank.
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized input must differ from the stable level before the stable level changes. Must be >= 1; a value of 0 is an elaboration error.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each per-bit counter; derived, not overridden.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous, active-high.
- I  input  NSWITCH  raw switch levels; asynchronous to CLK.
- Q  output  NSWITCH  debounced stable level per switch.
- ROSE  output  NSWITCH  one-cycle pulse when Q[n] goes 0->1.
- FELL  output  NSWITCH  one-cycle pulse when Q[n] goes 1->0.
- T  output  NSWITCH  toggle-mode level; see Optional Feature.

Behaviour:
- Reset (RST high at a rising edge) clears all of the following to 0: s1, s2, the counters, Q, ROSE, FELL and T. Reset wins over every other update in the same cycle.
- Synchronizer: s1[n] <= I[n]; s2[n] <= s1[n]. No logic between the two flops.
- Per-bit debounce, evaluated on each edge:
  - If s2[n] == Q[n]: cnt[n] <= 0.
  - Else if cnt[n] == DEBOUNCE_CYCLES-1: Q[n] <= s2[n], cnt[n] <= 0, and pulse ROSE[n] (if s2=1) or FELL[n] (if s2=0).
  - Else: cnt[n] <= cnt[n]+1.
- ROSE and FELL are registered and high for exactly one cycle, aligned with the cycle in which Q first shows the new value. ROSE[n] and FELL[n] are never high together.
- Latency: let I[n] change before edge 0 and then hold. Then s1 updates at edge 0, s2 at edge 1, and Q/ROSE/FELL update at edge DEBOUNCE_CYCLES+1. With the default of 4 this is edge 5; with DEBOUNCE_CYCLES=1 it is edge 2.
- Glitch rejection: any s2 excursion lasting fewer than DEBOUNCE_CYCLES cycles clears the counter on return and produces no Q change and no pulse.
- Bits are fully independent. Simultaneous transitions on several bits yield simultaneous pulses on those bits.
- Switch held high across reset release: Q starts at 0 and rises after the normal latency, producing one ROSE. This is intended.
- Reset asserted mid-count aborts the count; no pulse is emitted for the aborted transition.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.

Optional Feature:
- Macro: SWITCH_COND_TOGGLE_EN.
- Defined: T[n] <= ~T[n] on every cycle ROSE[n] is high, so each press-release of a lever flips T once. T resets to 0 and changes in the same cycle Q rises.
- Undefined: T is driven constant 0 and no toggle flops are instantiated.
- All other ports and timing are identical in both builds.

Test Plan:
- Reset then steady I=2'b00 -> Q=00, ROSE=00, FELL=00, T=00 for 20 cycles.
- I: 00->01, held (D=4) -> Q=01 after edge 5, ROSE=01 for exactly one cycle, FELL=00; I: 01->00 -> FELL=01 pulse 5 edges later.
- Glitch: I[1] high for 3 cycles (as seen at s2), then low -> Q[1] stays 0, no pulse; high for 4 cycles -> Q[1]=1 and ROSE[1] pulses.
- Both bits rise in the same cycle -> ROSE=11 in a single cycle, Q=11.
- RST asserted at count 2 during a rise, released with I held high -> no pulse while in reset; Q rises 5 edges after release.
- Toggle build (SWITCH_COND_TOGGLE_EN): three clean press/release cycles on bit 0 -> T[0] sequence 1,0,1; non-toggle build -> T=00 throughout.
